// File: rtl/mod_reduce_25519.sv
// Fixed-latency reduction of a 512-bit product modulo p = 2^255 - 19.
// Folds the high part down using 2^256 = 38 and 2^255 = 19 (mod p), then makes one conditional subtract.
module mod_reduce_25519 #(
    parameter int N = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] prod,
    output logic [N-1:0]   result,
    output logic           busy,
    output logic           data_rdy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FOLD1 = 3'd1,
        FOLD2 = 3'd2,
        FOLD3 = 3'd3,
        CSUB  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [254:0] P255 = {{250{1'b1}}, 5'b01101};

    state_t       state;
    logic [511:0] w_p0;
    logic [262:0] w_p1;
    logic [255:0] w_p2;
    logic [254:0] w_p3;

    // w[255:0] + 38*w[511:256]; 38 = 32 + 4 + 2, bounded below 2^263
    function automatic logic [262:0] fold_38(input logic [511:0] v);
        logic [262:0] lo;
        logic [262:0] hi;
        lo = {7'd0, v[255:0]};
        hi = {7'd0, v[511:256]};
        return lo + (hi << 5) + (hi << 2) + (hi << 1);
    endfunction

    // v[254:0] + 19*v[262:255]; 19 = 16 + 2 + 1, bounded below 2^255 + 4845
    function automatic logic [255:0] fold_19_top(input logic [262:0] v);
        logic [255:0] lo;
        logic [255:0] t;
        lo = {1'b0, v[254:0]};
        t  = {248'd0, v[262:255]};
        return lo + (t << 4) + (t << 1) + t;
    endfunction

    // A set bit 255 implies the low part is tiny, so adding 19 cannot carry out
    function automatic logic [254:0] fold_19_bit(input logic [255:0] v);
        return v[254:0] + (v[255] ? 255'd19 : 255'd0);
    endfunction

    // Input is below 2^255 < 2p, so a single subtract canonicalises it
    function automatic logic [255:0] csub(input logic [254:0] v);
        if (v >= P255) begin
            return {1'b0, v - P255};
        end
        return {1'b0, v};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w_p0     <= '0;
            w_p1     <= '0;
            w_p2     <= '0;
            w_p3     <= '0;
            result   <= '0;
            busy     <= 1'b0;
            data_rdy <= 1'b0;
        end else begin
            data_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_p0  <= prod;
                        busy  <= 1'b1;
                        state <= FOLD1;
                    end
                end
                // stage 1: fold bits 511:256
                FOLD1: begin
                    w_p1  <= fold_38(w_p0);
                    state <= FOLD2;
                end
                // stage 2: fold bits 262:255
                FOLD2: begin
                    w_p2  <= fold_19_top(w_p1);
                    state <= FOLD3;
                end
                // stage 3: fold bit 255
                FOLD3: begin
                    w_p3  <= fold_19_bit(w_p2);
                    state <= CSUB;
                end
                // stage 4: canonical result
                CSUB: begin
                    result   <= csub(w_p3);
                    data_rdy <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
